// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher controller.
// Block bytes are big-endian: byte 0 occupies bits 0:7.
package aes_dec_pkg;

  localparam int NR = 10;

  typedef logic [0:127] aes_block_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_ARK = 3'd1,
    ISR      = 3'd2,
    ISB      = 3'd3,
    ARK      = 3'd4,
    IMC      = 3'd5,
    DONE     = 3'd6
  } dec_phase_e;

endpackage

// File: rtl/aes_sub_wait_cnt.sv
// Clearable wait counter covering the InvSubBytes bank latency.
// tc_o flags the cycle on which the bank result is valid.
module aes_sub_wait_cnt #(
  parameter int SUB_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int W = (SUB_LAT > 0) ? $clog2(SUB_LAT + 1) : 1;
  localparam logic [W-1:0] TC = W'(SUB_LAT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Sequencer for AES-128 decryption: owns the cipher state register
// and walks it through the inverse-cipher round schedule.
module aes_inv_cipher_ctrl
  import aes_dec_pkg::*;
#(
  parameter int SUB_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  aes_block_t   ct_in,
  output logic         out_valid,
  input  logic         out_ready,
  output aes_block_t   pt_out,
  output aes_block_t   dp_state,
  input  aes_block_t   isr_res,
  input  aes_block_t   isb_res,
  input  aes_block_t   imc_res,
  output rk_idx_t      rk_idx,
  input  aes_block_t   rk_in,
  output logic         busy,
  output logic [2:0]   phase
);

  dec_phase_e phase_q;
  aes_block_t state_q;
  rk_idx_t    round_q;
  rk_idx_t    rk_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       in_ready_q;
  logic       sub_tc;

  aes_sub_wait_cnt #(
    .SUB_LAT (SUB_LAT)
  ) u_wait (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (phase_q == ISR),
    .inc_i (phase_q == ISB),
    .tc_o  (sub_tc)
  );

  // rk_idx is loaded on entry to INIT_ARK/ARK so rk_in is valid there
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      rk_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (phase_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= ct_in;
            round_q    <= rk_idx_t'(NR - 1);
            rk_q       <= rk_idx_t'(NR);
            phase_q    <= INIT_ARK;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        INIT_ARK: begin
          state_q <= state_q ^ rk_in;
          phase_q <= ISR;
        end
        ISR: begin
          state_q <= isr_res;
          phase_q <= ISB;
        end
        ISB: begin
          if (sub_tc) begin
            state_q <= isb_res;
            rk_q    <= round_q;
            phase_q <= ARK;
          end
        end
        ARK: begin
          state_q <= state_q ^ rk_in;
          if (round_q == '0) begin
            phase_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            phase_q <= IMC;
          end
        end
        IMC: begin
          state_q <= imc_res;
          round_q <= round_q - 1'b1;
          phase_q <= ISR;
        end
        DONE: begin
          if (out_ready) begin
            phase_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          phase_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pt_out    = state_q;
  assign dp_state  = state_q;
  assign rk_idx    = rk_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench: AES round functions and key schedule modelled in plain
// GF(2^8) arithmetic around two controllers (SUB_LAT=1 and 0).
module tb_aes_inv_cipher_ctrl;
  import aes_dec_pkg::*;

  localparam int NU = 2;
  localparam aes_block_t C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_block_t C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t C1_INIT = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid  [NU];
  logic       in_ready  [NU];
  aes_block_t ct_in     [NU];
  logic       out_valid [NU];
  logic       out_ready [NU];
  aes_block_t pt_out    [NU];
  aes_block_t dp_state  [NU];
  aes_block_t isr_res   [NU];
  aes_block_t isb_res   [NU];
  aes_block_t imc_res   [NU];
  rk_idx_t    rk_idx    [NU];
  aes_block_t rk_in     [NU];
  logic       busy      [NU];
  logic [2:0] phase     [NU];

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];
  aes_block_t rk    [11];

  int total = 0;
  int bad = 0;

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic aes_block_t isr_f(aes_block_t s);
    aes_block_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
    return o;
  endfunction

  function automatic aes_block_t isb_f(aes_block_t s);
    aes_block_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = isbox[s[8*i +: 8]];
    return o;
  endfunction

  function automatic aes_block_t imc_f(aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = gm(a0,14)^gm(a1,11)^gm(a2,13)^gm(a3,9);
      o[8*(4*c+1) +: 8] = gm(a0,9)^gm(a1,14)^gm(a2,11)^gm(a3,13);
      o[8*(4*c+2) +: 8] = gm(a0,13)^gm(a1,9)^gm(a2,14)^gm(a3,11);
      o[8*(4*c+3) +: 8] = gm(a0,11)^gm(a1,13)^gm(a2,9)^gm(a3,14);
    end
    return o;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      if (a == 0) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gm(inv, 8'(a));
      b = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3)
        ^ rotl8(inv,4) ^ 8'h63;
      sbox[a] = b;
      isbox[b] = 8'(a);
    end
  endtask

  task automatic set_key(aes_block_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic aes_block_t dec_ref(aes_block_t ct);
    aes_block_t s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) begin
      s = isb_f(isr_f(s)) ^ rk[r];
      s = imc_f(s);
    end
    return isb_f(isr_f(s)) ^ rk[0];
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_u
    aes_block_t isb_q;
    aes_inv_cipher_ctrl #(
      .SUB_LAT ((g == 0) ? 1 : 0)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .ct_in     (ct_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .pt_out    (pt_out[g]),
      .dp_state  (dp_state[g]),
      .isr_res   (isr_res[g]),
      .isb_res   (isb_res[g]),
      .imc_res   (imc_res[g]),
      .rk_idx    (rk_idx[g]),
      .rk_in     (rk_in[g]),
      .busy      (busy[g]),
      .phase     (phase[g])
    );
    always_comb isr_res[g] = isr_f(dp_state[g]);
    always_comb imc_res[g] = imc_f(dp_state[g]);
    always_comb rk_in[g] = (rk_idx[g] <= 4'd10) ? rk[rk_idx[g]] : '0;
    always @(posedge clk) isb_q <= isb_f(dp_state[g]);
    if (g == 0) begin : g_reg
      always_comb isb_res[g] = isb_q;
    end else begin : g_comb
      always_comb isb_res[g] = isb_f(dp_state[g]);
    end
  end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic accept(int u, aes_block_t ct);
    int n = 0;
    while (!in_ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 128'(in_ready[u]), 128'd1);
    in_valid[u] = 1'b1;
    ct_in[u] = ct;
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic run_op(int u, aes_block_t ct, aes_block_t exp_pt,
                        bit pulse, bit hold, bit c1);
    int n = 0;
    int slat = (u == 0) ? 1 : 0;
    logic [3:0] seq [$];
    logic [43:0] got_v, exp_v;
    aes_block_t pt_s;
    out_ready[u] = 1'b0;
    accept(u, ct);
    while (!out_valid[u] && n < 200) begin
      if (phase[u] == 3'd1 || phase[u] == 3'd4) seq.push_back(rk_idx[u]);
      if (c1 && n == 1) chk("init_ark", dp_state[u], C1_INIT);
      if (pulse && n == 5) begin
        in_valid[u] = 1'b1;
        ct_in[u] = ~ct;
      end
      if (n == 6) in_valid[u] = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(10 * slat + 40));
    chk("pt", pt_out[u], exp_pt);
    got_v = '0;
    exp_v = '0;
    for (int i = 0; i < 11; i++) begin
      exp_v = {exp_v[39:0], 4'(10 - i)};
      got_v = {got_v[39:0], (i < seq.size()) ? seq[i] : 4'hf};
    end
    chk("rk_seq", 128'(got_v), 128'(exp_v));
    if (hold) begin
      pt_s = pt_out[u];
      repeat (20) begin
        @(negedge clk);
        chk("hold_ov", 128'(out_valid[u]), 128'd1);
        chk("hold_pt", pt_out[u], pt_s);
        chk("hold_ir", 128'(in_ready[u]), 128'd0);
      end
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk("ret_phase", 128'(phase[u]), 128'd0);
    chk("ret_ir", 128'(in_ready[u]), 128'd1);
    chk("ret_ov", 128'(out_valid[u]), 128'd0);
  endtask

  task automatic chk_idle(int u);
    chk("rst_phase", 128'(phase[u]), 128'd0);
    chk("rst_ov", 128'(out_valid[u]), 128'd0);
    chk("rst_busy", 128'(busy[u]), 128'd0);
    chk("rst_dp", dp_state[u], '0);
  endtask

  task automatic abort_op(int u);
    int n = 0;
    int cnt = 0;
    logic [2:0] pv = 3'd0;
    accept(u, C1_CT);
    while (n < 200) begin
      if (phase[u] == 3'd3 && pv != 3'd3) begin
        cnt++;
        if (cnt == 5) break;
      end
      pv = phase[u];
      @(negedge clk);
      n++;
    end
    chk("abort_isb", 128'(phase[u]), 128'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle(u);
  endtask

  task automatic b2b(int u, aes_block_t cta, aes_block_t ctb);
    int n = 0;
    int acc [$];
    int rise [$];
    aes_block_t got [$];
    logic [2:0] pv = phase[u];
    logic pov = out_valid[u];
    out_ready[u] = 1'b1;
    in_valid[u] = 1'b1;
    ct_in[u] = cta;
    while (rise.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
      if (phase[u] == 3'd1 && pv == 3'd0) begin
        acc.push_back(n);
        ct_in[u] = ctb;
        if (acc.size() == 2) in_valid[u] = 1'b0;
      end
      if (out_valid[u] && !pov) begin
        rise.push_back(n);
        got.push_back(pt_out[u]);
      end
      pv = phase[u];
      pov = out_valid[u];
    end
    @(negedge clk);
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b0;
    chk("b2b_n", 128'(rise.size()), 128'd2);
    if (rise.size() == 2 && acc.size() == 2) begin
      chk("b2b_pt0", got[0], dec_ref(cta));
      chk("b2b_pt1", got[1], dec_ref(ctb));
      chk("b2b_gap", 128'((acc[1] - rise[0]) >= 2), 128'd1);
    end
  endtask

  function automatic aes_block_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    aes_block_t k, c;
    reset = 1'b1;
    for (int u = 0; u < NU; u++) begin
      in_valid[u] = 1'b0;
      out_ready[u] = 1'b0;
      ct_in[u] = '0;
    end
    init_tables();
    set_key(C1_KEY);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      set_key(C1_KEY);
      chk_idle(u);
      chk("rst_ir", 128'(in_ready[u]), 128'd1);
      chk("rst_rk", 128'(rk_idx[u]), 128'd0);
      chk("ref_c1", dec_ref(C1_CT), C1_PT);
      run_op(u, C1_CT, C1_PT, 1'b1, 1'b1, 1'b1);
      abort_op(u);
      run_op(u, C1_CT, C1_PT, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        k = rnd128();
        c = rnd128();
        set_key(k);
        run_op(u, c, dec_ref(c), 1'b0, 1'b0, 1'b0);
      end
      b2b(u, rnd128(), rnd128());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
